// File: rtl/game_sequencer.sv
// Gravity-runner round controller: roster latch, countdown, play/score, winner report.
// A free-running divider produces the game tick that paces the countdown and the score.
module game_sequencer #(
  parameter int TICK_DIV        = 1250000,
  parameter int COUNTDOWN_TICKS = 240,
  parameter int SCORE_W         = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         p_en,
  input  logic [3:0]         dead,
  output logic               game_tick,
  output logic [3:0]         play,
  output logic               enable_board,
  output logic [1:0]         state,
  output logic [7:0]         cd_remaining,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         winner,
  output logic               game_over
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, COUNTDOWN, PLAYING, GAME_OVER} state_t;

  state_t             st, st_nx;
  logic [CNT_W-1:0]   cnt;
  logic               start_q;
  logic               start_rise;
  logic [3:0]         alive;
  logic [2:0]         n_play, n_alive;
  logic [3:0]         play_nx, winner_nx;
  logic [7:0]         cd_nx;
  logic [SCORE_W-1:0] score_nx;

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  assign game_tick  = (cnt == CNT_W'(TICK_DIV - 1));
  assign start_rise = start & ~start_q;
  // Non-roster players are masked out, so their dead flags never matter.
  assign alive      = play & ~dead;
  assign n_play     = popcnt4(play);
  assign n_alive    = popcnt4(alive);
  assign state      = st;

  always_comb begin
    st_nx     = st;
    play_nx   = play;
    cd_nx     = cd_remaining;
    score_nx  = score;
    winner_nx = winner;
    unique case (st)
      IDLE: begin
        if (start_rise && p_en != 4'd0) begin
          play_nx = p_en;
          cd_nx   = 8'(COUNTDOWN_TICKS);
          st_nx   = COUNTDOWN;
        end
      end
      COUNTDOWN: begin
        if (game_tick) begin
          cd_nx = cd_remaining - 8'd1;
          if (cd_remaining == 8'd1) st_nx = PLAYING;
        end
      end
      PLAYING: begin
        // Round end wins over the score bump in the same cycle.
        if ((n_play >= 3'd2 && n_alive <= 3'd1) || (n_play == 3'd1 && n_alive == 3'd0)) begin
          st_nx     = GAME_OVER;
          winner_nx = alive;
        end else if (game_tick && !(&score)) begin
          score_nx = score + 1'b1;
        end
      end
      GAME_OVER: begin
        if (start_rise) begin
          st_nx     = IDLE;
          play_nx   = 4'd0;
          cd_nx     = 8'd0;
          score_nx  = '0;
          winner_nx = 4'd0;
        end
      end
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      start_q      <= 1'b0;
      st           <= IDLE;
      play         <= 4'd0;
      cd_remaining <= 8'd0;
      score        <= '0;
      winner       <= 4'd0;
      enable_board <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      cnt          <= game_tick ? '0 : cnt + 1'b1;
      start_q      <= start;
      st           <= st_nx;
      play         <= play_nx;
      cd_remaining <= cd_nx;
      score        <= score_nx;
      winner       <= winner_nx;
      enable_board <= (st_nx == PLAYING);
      game_over    <= (st_nx == GAME_OVER);
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed round scenarios plus random traffic, each cycle's
// expected outputs come from a behavioural round model and are checked through a queue.
module tb_game_sequencer;
  localparam int TD = 4;
  localparam int CD = 3;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [3:0]    p_en, dead;
  logic          game_tick, enable_board, game_over;
  logic [3:0]    play, winner;
  logic [1:0]    state;
  logic [7:0]    cd_remaining;
  logic [SW-1:0] score;

  game_sequencer #(.TICK_DIV(TD), .COUNTDOWN_TICKS(CD), .SCORE_W(SW)) dut (
    .clk(clk), .reset(reset), .start(start), .p_en(p_en), .dead(dead),
    .game_tick(game_tick), .play(play), .enable_board(enable_board), .state(state),
    .cd_remaining(cd_remaining), .score(score), .winner(winner), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tick, play, board, state, cd, score, winner, over;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Round model: phase 0 idle, 1 countdown, 2 playing, 3 game over.
  int m_phase, m_cnt, m_play, m_cd, m_score, m_win, m_sq;

  task automatic model(input logic r, input logic s, input logic [3:0] pe, input logic [3:0] d);
    bit tick, rise;
    int alive, np, na;
    exp_t e;
    tick = (m_cnt == TD - 1);
    rise = s && !m_sq;
    if (r) begin
      m_phase = 0; m_cnt = 0; m_play = 0; m_cd = 0; m_score = 0; m_win = 0; m_sq = 0;
    end else begin
      m_sq  = s;
      m_cnt = (m_cnt + 1) % TD;
      case (m_phase)
        0: if (rise && pe != 0) begin m_play = pe; m_cd = CD; m_phase = 1; end
        1: if (tick) begin m_cd = m_cd - 1; if (m_cd == 0) m_phase = 2; end
        2: begin
          alive = m_play & ~int'(d);
          np = $countones(m_play[3:0]);
          na = $countones(alive[3:0]);
          if ((np >= 2 && na <= 1) || (np == 1 && na == 0)) begin
            m_phase = 3; m_win = alive;
          end else if (tick && m_score < (1 << SW) - 1) begin
            m_score = m_score + 1;
          end
        end
        default: if (rise) begin m_phase = 0; m_play = 0; m_score = 0; m_win = 0; m_cd = 0; end
      endcase
    end
    e.tick = (m_cnt == TD - 1); e.play = m_play; e.board = (m_phase == 2);
    e.state = m_phase; e.cd = m_cd; e.score = m_score; e.winner = m_win; e.over = (m_phase == 3);
    q.push_back(e);
  endtask

  task automatic step(input logic r, input logic s, input logic [3:0] pe, input logic [3:0] d);
    reset = r; start = s; p_en = pe; dead = d;
    model(r, s, pe, d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_n(input int n, input logic s, input logic [3:0] pe, input logic [3:0] d);
    for (int i = 0; i < n; i++) step(1'b0, s, pe, d);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("game_tick",    32'(game_tick),    e.tick);
      chk("play",         32'(play),         e.play);
      chk("enable_board", 32'(enable_board), e.board);
      chk("state",        32'(state),        e.state);
      chk("cd_remaining", 32'(cd_remaining), e.cd);
      chk("score",        32'(score),        e.score);
      chk("winner",       32'(winner),       e.winner);
      chk("game_over",    32'(game_over),    e.over);
    end
  end

  initial begin
    m_phase = 0; m_cnt = 0; m_play = 0; m_cd = 0; m_score = 0; m_win = 0; m_sq = 0;
    step(1, 0, 4'b0000, 4'b0000);
    step(1, 0, 4'b0000, 4'b0000);
    idle_n(9, 0, 4'b0000, 4'b0000);
    // Empty roster: start is ignored.
    step(0, 1, 4'b0000, 4'b0000);
    idle_n(3, 0, 4'b0000, 4'b0000);
    // Two players, start held the whole time, roster switches wiggle during countdown.
    step(0, 1, 4'b0101, 4'b0000);
    for (int i = 0; i < 12; i++) step(0, 1, 4'($urandom_range(0, 15)), 4'b0000);
    idle_n(10, 1, 4'b1111, 4'b1010);
    idle_n(3, 1, 4'b0000, 4'b0001);
    idle_n(3, 0, 4'b0000, 4'b0001);
    step(0, 1, 4'b0000, 4'b0000);
    idle_n(2, 0, 4'b0000, 4'b0000);
    // Simultaneous death of both players -> draw.
    step(0, 1, 4'b0011, 4'b0000);
    idle_n(20, 0, 4'b0000, 4'b0000);
    idle_n(3, 0, 4'b0000, 4'b0011);
    step(0, 1, 4'b0000, 4'b0000);
    idle_n(2, 0, 4'b0000, 4'b0000);
    // Single player survives 20+ ticks (saturation), then dies.
    step(0, 1, 4'b1000, 4'b0000);
    idle_n(100, 0, 4'b0000, 4'b0111);
    idle_n(3, 0, 4'b0000, 4'b1000);
    step(0, 1, 4'b0000, 4'b0000);
    idle_n(2, 0, 4'b0000, 4'b0000);
    // Reset in the middle of a round.
    step(0, 1, 4'b0111, 4'b0000);
    idle_n(20, 0, 4'b0000, 4'b0000);
    step(1, 0, 4'b0000, 4'b0000);
    idle_n(6, 0, 4'b0000, 4'b0000);
    // Random traffic.
    for (int i = 0; i < 700; i++) begin
      logic [3:0] d;
      for (int b = 0; b < 4; b++) d[b] = ($urandom_range(0, 23) == 0);
      step(($urandom_range(0, 127) == 0), ($urandom_range(0, 7) == 0),
           4'($urandom_range(0, 15)), d);
    end
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain actual=%0d expected=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
